// File: rtl/mat_vec_collector_if.sv
// Stream bundle for the matrix-vector collector: serial element input
// plus the packed-vector valid/ready output toward the consumer.
interface mat_vec_collector_if #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 3
);
  logic [DATA_W-1:0]         in_data;
  logic                      in_valid;
  logic [VEC_LEN*DATA_W-1:0] vec_data;
  logic                      vec_valid;
  logic                      vec_ready;

  modport master (
    output in_data, in_valid, vec_ready,
    input  vec_data, vec_valid
  );

  modport slave (
    input  in_data, in_valid, vec_ready,
    output vec_data, vec_valid
  );
endinterface

// File: rtl/mat_vec_collector.sv
// Regroups the systolic unit's serial result stream into VEC_LEN-element
// vectors and buffers them in a first-word-fall-through FIFO.
module mat_vec_collector #(
  parameter int DATA_W     = 16,
  parameter int VEC_LEN    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          rst_n,
  mat_vec_collector_if.slave            bus,
  input  logic                          clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frag_err,
  output logic [15:0]                   vec_count
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int VW    = VEC_LEN * DATA_W;

  logic              prev_valid;
  logic [IDX_W-1:0]  elem_idx;
  logic [IDX_W-1:0]  idx_eff;
  logic [DATA_W-1:0] partial [VEC_LEN];
  logic [VW-1:0]     new_vec;
  logic [VW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [15:0]       count_q;
  logic              complete;
  logic              frag;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  always_comb begin
    // A fresh in_valid burst always starts at slot 0.
    idx_eff  = (bus.in_valid && !prev_valid) ? '0 : elem_idx;
    complete = bus.in_valid && (idx_eff == IDX_W'(VEC_LEN - 1));
    frag     = !bus.in_valid && (elem_idx != '0);
    new_vec  = '0;
    for (int unsigned i = 0; i < VEC_LEN - 1; i++) begin
      new_vec[i*DATA_W +: DATA_W] = partial[i];
    end
    new_vec[(VEC_LEN-1)*DATA_W +: DATA_W] = bus.in_data;
    full          = (fifo_level == (AW+1)'(FIFO_DEPTH));
    bus.vec_valid = (fifo_level != '0);
    pop           = bus.vec_valid && bus.vec_ready;
    // A same-cycle pop frees the slot the completed vector needs.
    push          = complete && (!full || pop);
    drop          = complete && !push;
    bus.vec_data  = bus.vec_valid ? mem[rd_ptr] : '0;
    vec_count     = count_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      elem_idx   <= '0;
      for (int unsigned i = 0; i < VEC_LEN; i++) begin
        partial[i] <= '0;
      end
    end else begin
      prev_valid <= bus.in_valid;
      if (bus.in_valid) begin
        partial[idx_eff] <= bus.in_data;
        elem_idx         <= complete ? '0 : idx_eff + IDX_W'(1);
      end else begin
        elem_idx <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= new_vec;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      frag_err <= 1'b0;
      count_q  <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
      if (frag) begin
        frag_err <= 1'b1;
      end else if (clr) begin
        frag_err <= 1'b0;
      end
      if (push) begin
        count_q <= clr ? 16'd1 : count_q + 16'd1;
      end else if (clr) begin
        count_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mat_vec_collector.sv
// Scoreboard bench for mat_vec_collector: directed element streams push
// expected vectors; a monitor compares every vector the consumer accepts.
module tb_mat_vec_collector;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        frag_err;
  logic [15:0] vec_count;

  int checks   = 0;
  int failures = 0;
  logic [47:0] exp_q[$];

  mat_vec_collector_if #(.DATA_W(16), .VEC_LEN(3)) bus ();

  mat_vec_collector #(.DATA_W(16), .VEC_LEN(3), .FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr        (clr),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frag_err   (frag_err),
    .vec_count  (vec_count)
  );

  always #5 clock = ~clock;

  function automatic logic [47:0] v3(input logic [15:0] e0, input logic [15:0] e1,
                                     input logic [15:0] e2);
    return {e2, e1, e0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic c = 1'b0);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.vec_ready = r;
    clr           = c;
    @(posedge clock);
    #1;
  endtask

  // Monitor: handshake values are stable at the falling edge before the pop.
  initial begin
    forever begin
      @(negedge clock);
      if (rst_n && bus.vec_valid && bus.vec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%h expected=none", bus.vec_data);
        end else begin
          chk("sb_vec", {16'h0, bus.vec_data}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.vec_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_valid", 64'(bus.vec_valid), 64'd0);
    chk("rst_data", 64'(bus.vec_data), 64'd0);
    chk("rst_flags", {62'd0, overflow, frag_err}, 64'd0);
    chk("rst_count", 64'(vec_count), 64'd0);
    rst_n = 1'b1;
    cyc(0, 0, 0);

    // 1: single vector, consumer ready
    exp_q.push_back(v3(16'd95, 16'd14, 16'd19));
    cyc(1, 16'd95, 1);
    cyc(1, 16'd14, 1);
    cyc(1, 16'd19, 1);
    chk("t1_valid", 64'(bus.vec_valid), 64'd1);
    cyc(0, 0, 1);
    chk("t1_level", 64'(fifo_level), 64'd0);
    chk("t1_count", 64'(vec_count), 64'd1);
    chk("t1_valid_off", 64'(bus.vec_valid), 64'd0);

    // 2: fill FIFO with four vectors, consumer stalled
    for (int i = 1; i <= 12; i++) cyc(1, 16'(i), 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(v3(16'(3*k+1), 16'(3*k+2), 16'(3*k+3)));
    cyc(0, 0, 0);
    chk("t2_level", 64'(fifo_level), 64'd4);
    chk("t2_overflow", 64'(overflow), 64'd0);
    chk("t2_head", 64'(bus.vec_data), 64'(v3(16'd1, 16'd2, 16'd3)));
    cyc(0, 0, 0);
    chk("t2_hold", 64'(bus.vec_data), 64'(v3(16'd1, 16'd2, 16'd3)));
    repeat (4) cyc(0, 0, 1);
    chk("t2_drained", 64'(fifo_level), 64'd0);
    chk("t2_count", 64'(vec_count), 64'd5);

    // 3a: fifth vector dropped when full
    cyc(0, 0, 0, 1);
    chk("t3_clr_count", 64'(vec_count), 64'd0);
    for (int i = 21; i <= 35; i++) cyc(1, 16'(i), 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(v3(16'(21+3*k), 16'(22+3*k), 16'(23+3*k)));
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_level", 64'(fifo_level), 64'd4);
    chk("t3_count", 64'(vec_count), 64'd4);
    repeat (4) cyc(0, 0, 1);
    chk("t3_drained", 64'(fifo_level), 64'd0);
    cyc(0, 0, 0, 1);
    chk("t3_clr_ovf", 64'(overflow), 64'd0);

    // 3b: pop on the completion cycle of the fifth vector keeps it
    for (int i = 41; i <= 52; i++) cyc(1, 16'(i), 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(v3(16'(41+3*k), 16'(42+3*k), 16'(43+3*k)));
    exp_q.push_back(v3(16'd53, 16'd54, 16'd55));
    cyc(1, 16'd53, 0);
    cyc(1, 16'd54, 0);
    cyc(1, 16'd55, 1);
    chk("t3b_level", 64'(fifo_level), 64'd4);
    chk("t3b_overflow", 64'(overflow), 64'd0);
    chk("t3b_count", 64'(vec_count), 64'd5);
    repeat (4) cyc(0, 0, 1);
    chk("t3b_drained", 64'(fifo_level), 64'd0);

    // 4: fragment then negative-valued vector, clear, set-wins-over-clr
    cyc(0, 0, 1, 1);
    cyc(1, 16'd7, 1);
    cyc(1, 16'd8, 1);
    cyc(0, 0, 1);
    chk("t4_frag", 64'(frag_err), 64'd1);
    chk("t4_frag_level", 64'(fifo_level), 64'd0);
    exp_q.push_back(v3(16'hFFFF, 16'hFFFE, 16'hFFFD));
    cyc(1, 16'hFFFF, 1);
    cyc(1, 16'hFFFE, 1);
    cyc(1, 16'hFFFD, 1);
    cyc(0, 0, 1);
    chk("t4_count", 64'(vec_count), 64'd1);
    cyc(0, 0, 1, 1);
    chk("t4_clr_frag", 64'(frag_err), 64'd0);
    chk("t4_clr_count", 64'(vec_count), 64'd0);
    cyc(1, 16'd1, 1);
    cyc(1, 16'd2, 1);
    cyc(0, 0, 1, 1);
    chk("t4_set_wins", 64'(frag_err), 64'd1);
    cyc(0, 0, 1, 1);
    chk("t4_clr2", 64'(frag_err), 64'd0);

    // 5: async reset mid-vector with two vectors stored
    for (int i = 61; i <= 68; i++) cyc(1, 16'(i), 0);
    chk("t5_pre_level", 64'(fifo_level), 64'd2);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_level", 64'(fifo_level), 64'd0);
    chk("t5_rst_valid", 64'(bus.vec_valid), 64'd0);
    chk("t5_rst_data", 64'(bus.vec_data), 64'd0);
    chk("t5_rst_count", 64'(vec_count), 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    exp_q.push_back(v3(16'd200, 16'd201, 16'd202));
    cyc(1, 16'd200, 1);
    cyc(1, 16'd201, 1);
    cyc(1, 16'd202, 1);
    cyc(0, 0, 1);
    chk("t5_level", 64'(fifo_level), 64'd0);
    chk("t5_count", 64'(vec_count), 64'd1);

    // 6: vec_count wrap from 0xFFFF
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    chk("t6_preset", 64'(vec_count), 64'hFFFF);
    exp_q.push_back(v3(16'd5, 16'd6, 16'd7));
    cyc(1, 16'd5, 1);
    cyc(1, 16'd6, 1);
    cyc(1, 16'd7, 1);
    cyc(0, 0, 1);
    chk("t6_wrap", 64'(vec_count), 64'd0);

    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
